des_round_ctrl: RTL

//  Iterative DES core controller: accepts a 64-bit block and applies the existing IP permutation.

---
 rtl/des_pkg.sv | 30 +++
 rtl/des_fp.sv | 15 +
 rtl/des_ip.sv | 25 ++
 rtl/des_round_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg -- shared definitions for the iterative DES round controller.
//   Block/half widths, the default round count, the controller state
//   encoding and the final-permutation index table.
//   Bit order throughout: vector bit i carries DES bit i+1.
package des_pkg;

  localparam int DES_ROUNDS = 16;
  localparam int DES_BLK_W  = 64;
  localparam int DES_HALF_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } des_state_e;

  // Final permutation, 1-based DES numbering: output DES bit i+1 takes
  // input DES bit DES_FP_TBL[i].
  localparam int DES_FP_TBL [DES_BLK_W] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

endpackage

// File: rtl/des_fp.sv
// des_fp -- DES final permutation (inverse of IP), purely combinational.
//   din  in  64  pre-output R16||L16, bit i = DES bit i+1 (R16 in [31:0])
//   dout out 64  FP(din), same bit order
module des_fp
  import des_pkg::*;
(
  input  logic [DES_BLK_W-1:0] din,
  output logic [DES_BLK_W-1:0] dout
);

  for (genvar gi = 0; gi < DES_BLK_W; gi++) begin : g_bit
    assign dout[gi] = din[DES_FP_TBL[gi] - 1];
  end

endmodule

// File: rtl/des_ip.sv
// des_ip -- DES initial permutation, purely combinational.
//   din  in  64  block, bit i = DES bit i+1
//   dout out 64  IP(din), same bit order
module des_ip (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  // Output DES bit i+1 takes input DES bit IP_TBL[i].
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  for (genvar gi = 0; gi < 64; gi++) begin : g_bit
    assign dout[gi] = din[IP_TBL[gi] - 1];
  end

endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl -- iterative DES controller, one Feistel round per clock.
//   Accepts a block on a valid/ready handshake, applies IP, runs ROUNDS
//   rounds through an external combinational f, applies FP and holds the
//   result on a valid/ready output handshake.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake, data_in 64-bit block
//   f_r, f_kidx         current R half and subkey index to the f datapath
//   f_out               f(R, K[f_kidx]), used in the same cycle
//   out_valid/out_ready output handshake, data_out 64-bit result
//   busy                high while rounds are running
//   decrypt             (DES_DECRYPT_EN only) per-block reverse key order
// Configuration
//   DES_DECRYPT_EN : adds the decrypt input; subkeys run ROUNDS-1 down to 0.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DES_BLK_W-1:0]  data_in,
`ifdef DES_DECRYPT_EN
  input  logic                  decrypt,
`endif
  output logic [DES_HALF_W-1:0] f_r,
  output logic [3:0]            f_kidx,
  input  logic [DES_HALF_W-1:0] f_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DES_BLK_W-1:0]  data_out,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ROUND = ROUND;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [4:0] LAST_CNT  = 5'(ROUNDS - 1);
  localparam logic [3:0] LAST_KIDX = 4'(ROUNDS - 1);

  logic [1:0]            state_reg;
  logic [DES_HALF_W-1:0] l_reg;
  logic [DES_HALF_W-1:0] r_reg;
  logic [4:0]            cnt_reg;
`ifdef DES_DECRYPT_EN
  logic                  dec_reg;
`endif

  logic [DES_BLK_W-1:0]  ip_blk;
  logic [DES_BLK_W-1:0]  fp_blk;
  logic [DES_HALF_W-1:0] r_new;
  logic                  last_round;

  des_ip u_ip (
    .din  (data_in),
    .dout (ip_blk)
  );

  assign r_new      = l_reg ^ f_out;
  assign last_round = (cnt_reg == LAST_CNT);

  // Pre-output is R16||L16 in DES order: R16 (this cycle's new R) lands in
  // the low half, L16 (current R) in the high half -- the final swap.
  des_fp u_fp (
    .din  ({r_reg, r_new}),
    .dout (fp_blk)
  );

  assign f_r  = r_reg;
  assign busy = (state_reg == ST_ROUND);

  // Subkey index is only meaningful in ROUND; elsewhere it parks at 0.
  always_comb begin
    f_kidx = 4'd0;
    if (state_reg == ST_ROUND) begin
`ifdef DES_DECRYPT_EN
      f_kidx = dec_reg ? (LAST_KIDX - cnt_reg[3:0]) : cnt_reg[3:0];
`else
      f_kidx = cnt_reg[3:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      l_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
`ifdef DES_DECRYPT_EN
      dec_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            l_reg     <= ip_blk[DES_HALF_W-1:0];
            r_reg     <= ip_blk[DES_BLK_W-1:DES_HALF_W];
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= ST_ROUND;
`ifdef DES_DECRYPT_EN
            dec_reg   <= decrypt;
`endif
          end else begin
            // in_ready is registered, so it rises one cycle into IDLE.
            in_ready <= 1'b1;
          end
        end
        ST_ROUND: begin
          l_reg <= r_reg;
          r_reg <= r_new;
          if (last_round) begin
            data_out  <= fp_blk;
            out_valid <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            // Counter holds at ROUNDS-1 instead of wrapping.
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
